// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file writeback controller.
// Default geometry and the queue entry layout live here so the queue and
// the top agree on them.
package regfile_wb_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;

  // One pending long-latency write at the default geometry.
  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] wa;
    logic [DW_DEF-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue.sv
// Pending-write queue for regfile_wb: circular buffer with extra-MSB
// pointers, full/empty flags and a per-entry squash compare against the
// newer writes (accepted push and ALU write) of the current cycle.
module regfile_wb_queue
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [AW-1:0]    push_wa,
  input  logic [DW-1:0]    push_wd,
  input  logic             alu_kill,
  input  logic [AW-1:0]    alu_wa,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_live,
  output logic [AW-1:0]    head_wa,
  output logic [DW-1:0]    head_wd,
  output logic [DEPTH-1:0] ent_valid,
  output logic [AW-1:0]    ent_wa [DEPTH],
  output logic [DW-1:0]    ent_wd [DEPTH]
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0]      head;
  logic [IW:0]      tail;
  logic [IW-1:0]    hidx;
  logic [IW-1:0]    tidx;
  logic [DEPTH-1:0] kill;
  logic             push_keep;

  assign hidx  = head[IW-1:0];
  assign tidx  = tail[IW-1:0];
  assign full  = (head[IW] != tail[IW]) && (hidx == tidx);
  assign empty = (head == tail);

  assign head_wa = ent_wa[hidx];
  assign head_wd = ent_wd[hidx];

  // A pushed entry is born squashed when the ALU writes the same register.
  assign push_keep = !(alu_kill && (alu_wa == push_wa));

  // The head only drains a value if it survives this cycle's squash check.
  assign head_live = !empty && ent_valid[hidx]
                   && !(push && (push_wa == head_wa))
                   && !(alu_kill && (alu_wa == head_wa));

  // Entries made stale by a newer write to the same register this cycle.
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = (push && (ent_wa[i] == push_wa))
             || (alu_kill && (ent_wa[i] == alu_wa));
    end
  end

  // Pointers and valid bits; popped slots are cleared so only live entries
  // ever show valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) ent_valid[i] <= 1'b0;
      end
      if (pop) begin
        ent_valid[hidx] <= 1'b0;
        head            <= head + 1'b1;
      end
      if (push) begin
        ent_valid[tidx] <= push_keep;
        tail            <= tail + 1'b1;
      end
    end
  end

  // Entry payload storage; needs no reset since valid bits gate its use.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_wa[tidx] <= push_wa;
      ent_wd[tidx] <= push_wd;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Writeback controller owning the register file's single write port.
// ALU writes go straight through; long-latency results queue and drain on
// idle port cycles; stale queued writes are squashed.
// Build option: define REGFILE_WB_FWD_EN to enable forwarding of pending
// values to ra1/ra2; otherwise the fwd outputs are 0 and decode must stall
// on !empty.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_we,
  input  logic [AW-1:0] alu_wa,
  input  logic [DW-1:0] alu_wd,
  input  logic          ll_valid,
  output logic          ll_ready,
  input  logic [AW-1:0] ll_wa,
  input  logic [DW-1:0] ll_wd,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          fwd1_hit,
  output logic          fwd2_hit,
  output logic [DW-1:0] fwd1_data,
  output logic [DW-1:0] fwd2_data,
  output logic          empty
);

  logic             alu_act;
  logic             push;
  logic             pop;
  logic             full;
  logic             head_live;
  logic [AW-1:0]    head_wa;
  logic [DW-1:0]    head_wd;
  logic [DEPTH-1:0] ent_valid;
  logic [AW-1:0]    ent_wa [DEPTH];
  logic [DW-1:0]    ent_wd [DEPTH];

  assign alu_act  = alu_we && (alu_wa != '0);
  assign ll_ready = !full;
  // Handshakes to register 0 complete but enqueue nothing.
  assign push     = ll_valid && ll_ready && (ll_wa != '0);
  // The head leaves whenever the ALU does not own the port, live or not.
  assign pop      = !reset && !alu_act && !empty;

  regfile_wb_queue #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_wa  (ll_wa),
    .push_wd  (ll_wd),
    .alu_kill (alu_act),
    .alu_wa   (alu_wa),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head_live(head_live),
    .head_wa  (head_wa),
    .head_wd  (head_wd),
    .ent_valid(ent_valid),
    .ent_wa   (ent_wa),
    .ent_wd   (ent_wd)
  );

  // Write-port arbitration: ALU first, then a surviving queue head.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (!reset) begin
      if (alu_act) begin
        rf_we = 1'b1;
        rf_wa = alu_wa;
        rf_wd = alu_wd;
      end else if (head_live) begin
        rf_we = 1'b1;
        rf_wa = head_wa;
        rf_wd = head_wd;
      end
    end
  end

`ifdef REGFILE_WB_FWD_EN
  // Newest pending value per read port: the write in flight beats the
  // queue; at most one valid entry per register, so no age compare.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_wa[i] == ra1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = ent_wd[i];
      end
      if (ent_valid[i] && (ent_wa[i] == ra2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = ent_wd[i];
      end
    end
    if (rf_we && (rf_wa == ra1)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = rf_wd;
    end
    if (rf_we && (rf_wa == ra2)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = rf_wd;
    end
    if (ra1 == '0) begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
    end
    if (ra2 == '0) begin
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
    end
  end
`else
  logic unused_fwd;

  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;

  // Entry view and read addresses have no consumer without forwarding.
  always_comb begin
    unused_fwd = ^{ra1, ra2, ent_valid};
    for (int i = 0; i < DEPTH; i++) begin
      unused_fwd = unused_fwd ^ (^{ent_wa[i], ent_wd[i]});
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb (DEPTH=4, AW=5, DW=32).
module tb_regfile_wb;

`ifdef REGFILE_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_we;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_wa;
  logic [31:0] ll_wd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic        empty;

  int tests = 0;
  int fails = 0;

  logic [31:0] shadow [32];
  int          nwr = 0;
  bit          wr0 = 1'b0;

  regfile_wb #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_we   (alu_we),
    .alu_wa   (alu_wa),
    .alu_wd   (alu_wd),
    .ll_valid (ll_valid),
    .ll_ready (ll_ready),
    .ll_wa    (ll_wa),
    .ll_wd    (ll_wd),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .ra1      (ra1),
    .ra2      (ra2),
    .fwd1_hit (fwd1_hit),
    .fwd2_hit (fwd2_hit),
    .fwd1_data(fwd1_data),
    .fwd2_data(fwd2_data),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // Record what reaches the register file.
  always @(posedge clk) begin
    if (rf_we) begin
      shadow[rf_wa] <= rf_wd;
      nwr           <= nwr + 1;
      if (rf_wa == 5'd0) wr0 <= 1'b1;
    end
  end

  task automatic idle();
    reset = 1'b0; alu_we = 1'b0; alu_wa = '0; alu_wd = '0;
    ll_valid = 1'b0; ll_wa = '0; ll_wd = '0; ra1 = '0; ra2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0; ra1 = 5'd3; ra2 = 5'd4;
    #1;
    tests++;
    if ({ll_ready, empty, rf_we, rf_wa, rf_wd, fwd1_hit, fwd2_hit} !== {3'b110, 37'h0, 2'b00}) begin
      fails++;
      $display("FAIL reset_idle got rdy=%b empty=%b we=%b wa=%0d wd=%h h1=%b h2=%b exp rdy=1 empty=1 rest 0",
               ll_ready, empty, rf_we, rf_wa, rf_wd, fwd1_hit, fwd2_hit);
    end
    tick();
  endtask

  task automatic test_alu();
    idle();
    alu_we = 1'b1; alu_wa = 5'd5; alu_wd = 32'h1234; ra1 = 5'd5; ra2 = 5'd0;
    #1;
    tests++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'h1234}) begin
      fails++;
      $display("FAIL alu_write got %b/%0d/%h exp 1/5/00001234", rf_we, rf_wa, rf_wd);
    end
    tests++;
    if ({fwd1_hit, fwd1_data, fwd2_hit} !== (FWD ? {1'b1, 32'h1234, 1'b0} : 34'h0)) begin
      fails++;
      $display("FAIL alu_fwd got h1=%b d1=%h h2=%b exp h1=%b d1=%h h2=0",
               fwd1_hit, fwd1_data, fwd2_hit, FWD, FWD ? 32'h1234 : 32'h0);
    end
    tick();
  endtask

  task automatic test_ll();
    // Plain push: no cut-through, written the following cycle.
    idle();
    ll_valid = 1'b1; ll_wa = 5'd7; ll_wd = 32'hAA;
    #1;
    tests++;
    if ({ll_ready, rf_we} !== 2'b10) begin
      fails++;
      $display("FAIL ll_push_cycle got rdy=%b we=%b exp rdy=1 we=0", ll_ready, rf_we);
    end
    tick();
    idle();
    #1;
    tests++;
    if ({rf_we, rf_wa, rf_wd, empty} !== {1'b1, 5'd7, 32'hAA, 1'b0}) begin
      fails++;
      $display("FAIL ll_drain got %b/%0d/%h empty=%b exp 1/7/000000aa empty=0", rf_we, rf_wa, rf_wd, empty);
    end
    tick();
    #1;
    tests++;
    if ({empty, rf_we} !== 2'b10) begin
      fails++;
      $display("FAIL ll_after_drain got empty=%b we=%b exp empty=1 we=0", empty, rf_we);
    end
    // Push, then ALU busy: entry waits and is forwarded.
    ll_valid = 1'b1; ll_wa = 5'd7; ll_wd = 32'hAA;
    tick();
    idle();
    alu_we = 1'b1; alu_wa = 5'd2; alu_wd = 32'h55; ra1 = 5'd7; ra2 = 5'd2;
    #1;
    tests++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd2, 32'h55}) begin
      fails++;
      $display("FAIL ll_alu_busy got %b/%0d/%h exp 1/2/00000055", rf_we, rf_wa, rf_wd);
    end
    tests++;
    if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data} !==
        (FWD ? {1'b1, 32'hAA, 1'b1, 32'h55} : 66'h0)) begin
      fails++;
      $display("FAIL ll_fwd got h1=%b d1=%h h2=%b d2=%h exp fwd_en=%b (aa/55 when enabled)",
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, FWD);
    end
    tick();
    idle();
    #1;
    tests++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd7, 32'hAA}) begin
      fails++;
      $display("FAIL ll_idle_drain got %b/%0d/%h exp 1/7/000000aa", rf_we, rf_wa, rf_wd);
    end
    tick();
  endtask

  task automatic test_fill();
    logic [37:0] exp;
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_we = 1'b1; alu_wa = 5'd1; alu_wd = 32'hF00 + i;
      ll_valid = 1'b1; ll_wa = 5'(10 + i); ll_wd = 32'h100 + i;
      #1;
      tests++;
      if (ll_ready !== 1'b1) begin
        fails++;
        $display("FAIL fill_ready_%0d got %b exp 1", i, ll_ready);
      end
      tick();
    end
    // Full: a further offer is refused while the ALU keeps the port.
    ll_valid = 1'b1; ll_wa = 5'd20; ll_wd = 32'hBAD;
    alu_wd = 32'hF04;
    #1;
    tests++;
    if ({ll_ready, rf_we, rf_wa} !== {1'b0, 1'b1, 5'd1}) begin
      fails++;
      $display("FAIL fill_full got rdy=%b we=%b wa=%0d exp rdy=0 we=1 wa=1", ll_ready, rf_we, rf_wa);
    end
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = {1'b1, 5'(10 + i), 32'h100 + i};
      tests++;
      if ({rf_we, rf_wa, rf_wd} !== exp) begin
        fails++;
        $display("FAIL fill_drain_%0d got %b/%0d/%h exp %b/%0d/%h",
                 i, rf_we, rf_wa, rf_wd, exp[37], exp[36:32], exp[31:0]);
      end
      tests++;
      if (ll_ready !== (i != 0)) begin
        fails++;
        $display("FAIL fill_ready_drain_%0d got %b exp %b", i, ll_ready, (i != 0));
      end
      tick();
    end
    #1;
    tests++;
    if ({empty, rf_we} !== 2'b10) begin
      fails++;
      $display("FAIL fill_empty got empty=%b we=%b exp empty=1 we=0", empty, rf_we);
    end
  endtask

  task automatic test_squash();
    // Queued write overtaken by a later ALU write.
    idle();
    ll_valid = 1'b1; ll_wa = 5'd9; ll_wd = 32'h11;
    tick();
    idle();
    alu_we = 1'b1; alu_wa = 5'd9; alu_wd = 32'h22;
    tick();
    idle();
    #1;
    tests++;
    if ({empty, rf_we, rf_wa, rf_wd} !== {1'b0, 1'b0, 37'h0}) begin
      fails++;
      $display("FAIL squash_alu_pop got empty=%b %b/%0d/%h exp empty=0 0/0/0", empty, rf_we, rf_wa, rf_wd);
    end
    tick();
    #1;
    tests++;
    if ({empty, shadow[9]} !== {1'b1, 32'h22}) begin
      fails++;
      $display("FAIL squash_alu_final got empty=%b r9=%h exp empty=1 r9=00000022", empty, shadow[9]);
    end
    // Push and ALU write to the same register in one cycle.
    ll_valid = 1'b1; ll_wa = 5'd9; ll_wd = 32'h33;
    alu_we = 1'b1; alu_wa = 5'd9; alu_wd = 32'h44;
    #1;
    tests++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd9, 32'h44}) begin
      fails++;
      $display("FAIL squash_same_cycle got %b/%0d/%h exp 1/9/00000044", rf_we, rf_wa, rf_wd);
    end
    tick();
    idle();
    #1;
    tests++;
    if ({empty, rf_we} !== 2'b00) begin
      fails++;
      $display("FAIL squash_same_pop got empty=%b we=%b exp empty=0 we=0", empty, rf_we);
    end
    tick();
    // Head squashed by a push in the very cycle it would drain.
    ll_valid = 1'b1; ll_wa = 5'd9; ll_wd = 32'h55;
    tick();
    ll_wd = 32'h66;
    #1;
    tests++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("FAIL squash_head_push got we=%b wa=%0d wd=%h exp we=0", rf_we, rf_wa, rf_wd);
    end
    tick();
    idle();
    #1;
    tests++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd9, 32'h66}) begin
      fails++;
      $display("FAIL squash_head_new got %b/%0d/%h exp 1/9/00000066", rf_we, rf_wa, rf_wd);
    end
    tick();
    #1;
    tests++;
    if ({empty, shadow[9]} !== {1'b1, 32'h66}) begin
      fails++;
      $display("FAIL squash_head_final got empty=%b r9=%h exp empty=1 r9=00000066", empty, shadow[9]);
    end
  endtask

  task automatic test_reg0_reset();
    int n0;
    idle();
    n0 = nwr;
    ll_valid = 1'b1; ll_wa = 5'd0; ll_wd = 32'hDEAD;
    #1;
    tests++;
    if (ll_ready !== 1'b1) begin
      fails++;
      $display("FAIL reg0_ready got %b exp 1", ll_ready);
    end
    tick();
    idle();
    #1;
    tests++;
    if ({empty, rf_we, wr0, nwr == n0} !== 4'b1001) begin
      fails++;
      $display("FAIL reg0_no_enqueue got empty=%b we=%b wr0=%b writes=%0d exp empty=1 we=0 wr0=0 writes=%0d",
               empty, rf_we, wr0, nwr, n0);
    end
    // Three live entries held behind the ALU, then reset.
    for (int i = 0; i < 3; i++) begin
      alu_we = 1'b1; alu_wa = 5'd1; alu_wd = 32'h700 + i;
      ll_valid = 1'b1; ll_wa = 5'(20 + i); ll_wd = 32'h200 + i;
      tick();
    end
    idle();
    reset = 1'b1;
    #1;
    tests++;
    if ({empty, rf_we} !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_cycle got empty=%b we=%b exp empty=0 we=0", empty, rf_we);
    end
    n0 = nwr;
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({empty, ll_ready, rf_we} !== 3'b110) begin
      fails++;
      $display("FAIL reset_mid_after got empty=%b rdy=%b we=%b exp empty=1 rdy=1 we=0", empty, ll_ready, rf_we);
    end
    tick();
    tick();
    #1;
    tests++;
    if (nwr != n0) begin
      fails++;
      $display("FAIL reset_no_writes got %0d writes exp %0d", nwr, n0);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ll();
    test_fill();
    test_squash();
    test_reg0_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
